// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: func3 codes,
// FSM state encoding and access-size helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StResp
   } lsu_state_e;

   // Number of bytes moved for a given width code (1, 2 or 4).
   function automatic logic [2:0] byte_count(input logic [2:0] func3);
      logic [2:0] n;
      case (func3[1:0])
         2'b00:   n = 3'd1;
         2'b01:   n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   // Index of the final byte; fits the 2-bit byte counter.
   function automatic logic [1:0] last_byte(input logic [2:0] func3);
      return 2'(byte_count(func3) - 3'd1);
   endfunction

   // Legal width code for the direction and naturally aligned address.
   function automatic logic req_legal(input logic       we,
                                      input logic [2:0] func3,
                                      input logic [1:0] addr_lo);
      logic ok;
      case (func3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_byte_master_if.sv
// Core-side request/response and memory-side byte port of the load/store unit.
interface lsu_byte_master_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_func3;
   logic [31:0]       req_wdata;

   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_error;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   // The load/store unit itself.
   modport master (
      input  req_valid, req_we, req_addr, req_func3, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   // Core plus memory environment around the unit.
   modport slave (
      output req_valid, req_we, req_addr, req_func3, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of an assembled little-endian load word by func3.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [31:0] word,
   output logic [31:0] ext
);

   // func3[2] selects zero extension; word loads pass through.
   always_comb begin
      ext = word;
      case (func3[1:0])
         2'b00:   ext = {{24{word[7] & ~func3[2]}}, word[7:0]};
         2'b01:   ext = {{16{word[15] & ~func3[2]}}, word[15:0]};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/lsu_byte_master.sv
// Byte-serial load/store initiator: accepts one RV32I load/store, checks
// alignment, issues 1/2/4 little-endian byte accesses and returns a single
// response pulse. All outputs come straight from registers.
module lsu_byte_master
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input logic                clk,
   input logic                rst,
   lsu_byte_master_if.master  bus
);

   lsu_state_e        state_q;
   logic              we_q;
   logic [2:0]        func3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [1:0]        k_q;
   logic [31:0]       asm_q;

   logic              ready_q;
   logic              resp_valid_q;
   logic              resp_error_q;
   logic [31:0]       resp_rdata_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;

   logic [1:0]        last_k;
   logic [1:0]        k_next;
   logic [1:0]        cap_idx;
   logic [31:0]       asm_next;
   logic [31:0]       ext_word;

   assign last_k = last_byte(func3_q);
   assign k_next = k_q + 2'd1;
   // Read data lags its strobe by one cycle; DRAIN holds k at the last byte.
   assign cap_idx = (state_q == StDrain) ? k_q : k_q - 2'd1;

   // Assembly word with the byte arriving this cycle merged in.
   always_comb begin
      asm_next = asm_q;
      asm_next[{cap_idx, 3'b000} +: 8] = bus.mem_rdata;
   end

   lsu_load_ext u_ext (
      .func3 (func3_q),
      .word  (asm_next),
      .ext   (ext_word)
   );

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_error = resp_error_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

   // Control FSM with registered outputs, byte counter and load assembly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         func3_q      <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= '0;
         k_q          <= 2'd0;
         asm_q        <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  func3_q <= bus.req_func3;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  k_q     <= 2'd0;
                  asm_q   <= '0;
                  ready_q <= 1'b0;
                  if (req_legal(bus.req_we, bus.req_func3, bus.req_addr[1:0])) begin
                     state_q     <= StIssue;
                     mem_en_q    <= 1'b1;
                     mem_we_q    <= bus.req_we;
                     mem_addr_q  <= bus.req_addr;
                     mem_wdata_q <= bus.req_wdata[7:0];
                  end else begin
                     // Rejected requests never touch the memory port.
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                     resp_error_q <= 1'b1;
                     resp_rdata_q <= '0;
                  end
               end
            end
            StIssue: begin
               if (!we_q && k_q != 2'd0) begin
                  asm_q <= asm_next;
               end
               if (k_q == last_k) begin
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if (we_q) begin
                     state_q      <= StResp;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= StDrain;
                  end
               end else begin
                  k_q         <= k_next;
                  mem_addr_q  <= addr_q + ADDR_W'(k_next);
                  mem_wdata_q <= wdata_q[{k_next, 3'b000} +: 8];
               end
            end
            StDrain: begin
               asm_q        <= asm_next;
               resp_rdata_q <= ext_word;
               resp_valid_q <= 1'b1;
               state_q      <= StResp;
            end
            StResp: begin
               resp_valid_q <= 1'b0;
               resp_error_q <= 1'b0;
               resp_rdata_q <= '0;
               ready_q      <= 1'b1;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed bench for lsu_byte_master with a byte memory model and a write log.
module tb_lsu_byte_master;

   logic clk;
   logic rst;

   lsu_byte_master_if #(.ADDR_W(32)) bus ();

   lsu_byte_master #(.ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Memory model and monitors
   logic [7:0]  mem [0:255];
   int          cyc = 0;
   int          en_cnt = 0;
   int          en0;
   logic [31:0] w_addr [$];
   logic [7:0]  w_data [$];
   int          w_cyc  [$];
   int          acc_q  [$];
   int          resp_q [$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_en) begin
         en_cnt <= en_cnt + 1;
         if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            w_addr.push_back(bus.mem_addr);
            w_data.push_back(bus.mem_wdata);
            w_cyc.push_back(cyc);
         end else begin
            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
         end
      end
      if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
      if (bus.resp_valid) resp_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      w_addr.delete();
      w_data.delete();
      w_cyc.delete();
      acc_q.delete();
      resp_q.delete();
      en0 = en_cnt;
   endtask

   // One request; lat counts cycles from accept edge to the resp_valid cycle.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err);
      int n;
      @(negedge clk);
      clear_logs();
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_func3 = f3;
      bus.req_wdata = wd;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rdata = bus.resp_rdata;
      err   = bus.resp_error;
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er;
   logic [31:0] sw_word;
   int          n;

   initial begin
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_func3 = 3'b000;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_error", 32'(bus.resp_error), 32'd0);
      chk("post_rst_wdata", 32'(bus.mem_wdata), 32'd0);

      // SW 0x10
      sw_word = 32'hDEADBEEF;
      do_req(1'b1, 32'h10, 3'b010, sw_word, lat, rd, er);
      chk("sw_lat", 32'(lat), 32'd5);
      chk("sw_err", 32'(er), 32'd0);
      chk("sw_rdata", rd, 32'd0);
      chk("sw_nwrites", 32'(w_addr.size()), 32'd4);
      chk("sw_nstrobes", 32'(en_cnt - en0), 32'd4);
      for (int i = 0; i < 4 && i < w_addr.size(); i++) begin
         chk("sw_waddr", w_addr[i], 32'h10 + 32'(i));
         chk("sw_wdata", 32'(w_data[i]), 32'(sw_word[8*i +: 8]));
         chk("sw_wcyc", 32'(w_cyc[i] - acc_q[0]), 32'(i + 1));
      end

      // Loads of the stored word
      do_req(1'b0, 32'h13, 3'b000, 32'h0, lat, rd, er);
      chk("lb_lat", 32'(lat), 32'd3);
      chk("lb_rdata", rd, 32'hFFFFFFDE);
      chk("lb_err", 32'(er), 32'd0);
      chk("lb_nowrite", 32'(w_addr.size()), 32'd0);
      do_req(1'b0, 32'h13, 3'b100, 32'h0, lat, rd, er);
      chk("lbu_rdata", rd, 32'h000000DE);
      do_req(1'b0, 32'h12, 3'b001, 32'h0, lat, rd, er);
      chk("lh_lat", 32'(lat), 32'd4);
      chk("lh_rdata", rd, 32'hFFFFDEAD);
      do_req(1'b0, 32'h12, 3'b101, 32'h0, lat, rd, er);
      chk("lhu_rdata", rd, 32'h0000DEAD);
      do_req(1'b0, 32'h10, 3'b001, 32'h0, lat, rd, er);
      chk("lh10_rdata", rd, 32'hFFFFBEEF);
      do_req(1'b0, 32'h10, 3'b010, 32'h0, lat, rd, er);
      chk("lw_lat", 32'(lat), 32'd6);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_err", 32'(er), 32'd0);
      chk("lw_nstrobes", 32'(en_cnt - en0), 32'd4);

      // Positive byte through SB then LB
      do_req(1'b1, 32'h14, 3'b000, 32'hAAAA557F, lat, rd, er);
      chk("sb_lat", 32'(lat), 32'd2);
      chk("sb_nwrites", 32'(w_addr.size()), 32'd1);
      do_req(1'b0, 32'h14, 3'b000, 32'h0, lat, rd, er);
      chk("lb_pos_rdata", rd, 32'h0000007F);

      // Illegal / misaligned requests
      do_req(1'b0, 32'h11, 3'b010, 32'h0, lat, rd, er);
      chk("lw_mis_lat", 32'(lat), 32'd1);
      chk("lw_mis_err", 32'(er), 32'd1);
      chk("lw_mis_rdata", rd, 32'd0);
      chk("lw_mis_nostrobe", 32'(en_cnt - en0), 32'd0);
      do_req(1'b1, 32'h12, 3'b101, 32'h12345678, lat, rd, er);
      chk("sh101_lat", 32'(lat), 32'd1);
      chk("sh101_err", 32'(er), 32'd1);
      chk("sh101_rdata", rd, 32'd0);
      chk("sh101_nostrobe", 32'(en_cnt - en0), 32'd0);
      do_req(1'b1, 32'h11, 3'b001, 32'h12345678, lat, rd, er);
      chk("sh_mis_err", 32'(er), 32'd1);
      chk("sh_mis_nowrite", 32'(w_addr.size()), 32'd0);
      do_req(1'b0, 32'h10, 3'b011, 32'h0, lat, rd, er);
      chk("ld011_err", 32'(er), 32'd1);

      // SW 0x20 aborted by reset after two bytes
      @(negedge clk);
      clear_logs();
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_func3 = 3'b010;
      bus.req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_nwrites", 32'(w_addr.size()), 32'd2);
      if (w_addr.size() >= 2) begin
         chk("abort_waddr0", w_addr[0], 32'h20);
         chk("abort_waddr1", w_addr[1], 32'h21);
         chk("abort_wdata1", 32'(w_data[1]), 32'hF0);
      end
      chk("abort_noresp", 32'(resp_q.size()), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);

      // Two SBs with req_valid held high
      @(negedge clk);
      clear_logs();
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h30;
      bus.req_func3 = 3'b000;
      bus.req_wdata = 32'h11;
      @(posedge clk);
      @(negedge clk);
      bus.req_addr  = 32'h31;
      bus.req_wdata = 32'h22;
      n = 0;
      while (acc_q.size() < 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid = 1'b0;
      n = 0;
      while (resp_q.size() < 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_naccept", 32'(acc_q.size()), 32'd2);
      chk("b2b_nresp", 32'(resp_q.size()), 32'd2);
      chk("b2b_nwrites", 32'(w_addr.size()), 32'd2);
      if (acc_q.size() == 2 && resp_q.size() >= 1)
         chk("b2b_after_resp", 32'(acc_q[1] > resp_q[0]), 32'd1);
      if (w_addr.size() == 2) begin
         chk("b2b_waddr0", w_addr[0], 32'h30);
         chk("b2b_wdata0", 32'(w_data[0]), 32'h11);
         chk("b2b_waddr1", w_addr[1], 32'h31);
         chk("b2b_wdata1", 32'(w_data[1]), 32'h22);
         chk("b2b_no_overlap", 32'(w_cyc[1] > w_cyc[0]), 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
